mod_exp: RTL

Modular exponentiation engine, result = base^exp mod modulus. Sits directly downstream of the modular-inverse stage. It consumes the private exponent d (or public e) with modulus n to perform RSA encrypt/decrypt. The engine is a sequential right-to-left square-and-multiply FSM. Every modular product is delegated to a bit-serial interleaved modular multiplier, so there is no wide combinational divide.

---
 rtl/mod_exp_pkg.sv | 30 +++
 rtl/mod_mul_serial.sv | 85 ++++++++
 rtl/mod_exp.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/mod_exp_pkg.sv
// -----------------------------------------------------------------------------
// mod_exp_pkg
// Shared definitions for the modular exponentiation engine:
//   - MOD_EXP_WIDTH : default operand width
//   - state_t       : control FSM state encoding
//   - MUL_LAT / mul_latency() : cycles from multiplier start to done
// -----------------------------------------------------------------------------
package mod_exp_pkg;

  localparam int MOD_EXP_WIDTH = 256;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RED  = 3'd2,
    ST_STEP = 3'd3,
    ST_MUL  = 3'd4,
    ST_SQR  = 3'd5,
    ST_DONE = 3'd6
  } state_t;

  // The bit-serial multiplier needs one cycle per operand bit plus the
  // cycle in which it captures its operands.
  function automatic int mul_latency(input int width);
    return width + 1;
  endfunction

  localparam int MUL_LAT = MOD_EXP_WIDTH + 1;

endpackage

// File: rtl/mod_mul_serial.sv
// -----------------------------------------------------------------------------
// mod_mul_serial
// Bit-serial interleaved modular multiplier: product = a * b mod m.
// Scans a MSB-first, one bit per cycle: R = 2R + a_i*b, then subtracts m at
// most twice. Requires b < m; a may be any WIDTH-bit value.
// Ports:
//   clk     : rising-edge clock
//   rst     : synchronous active-low reset (aborts an operation in flight)
//   start   : capture a/b/m and begin; restarts any running operation
//   a, b, m : operands
//   product : a*b mod m, valid while done is high and held afterwards
//   done    : one-cycle pulse WIDTH+1 cycles after the start cycle
// -----------------------------------------------------------------------------
module mod_mul_serial
  import mod_exp_pkg::*;
#(
  parameter int WIDTH = MOD_EXP_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] product,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 2);

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_r;
  logic [CW-1:0]    r_cnt;
  logic             r_run;

  // Accumulator is WIDTH+2 bits: with R < m and b < m, 2R + b < 3m.
  logic [WIDTH+1:0] w_add;
  logic [WIDTH+1:0] w_mx;
  logic [WIDTH+1:0] w_t0;
  logic [WIDTH+1:0] w_t1;
  logic [WIDTH-1:0] w_t2;

  assign w_add = r_a[WIDTH-1] ? {2'b00, r_b} : '0;
  assign w_mx  = {2'b00, r_m};
  assign w_t0  = {1'b0, r_r, 1'b0} + w_add;
  assign w_t1  = (w_t0 >= w_mx) ? (w_t0 - w_mx) : w_t0;
  // After the second conditional subtract the value is < m, so it fits WIDTH.
  assign w_t2  = (w_t1 >= w_mx) ? WIDTH'(w_t1 - w_mx) : w_t1[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_m     <= '0;
      r_r     <= '0;
      r_cnt   <= '0;
      r_run   <= 1'b0;
      product <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        r_a   <= a;
        r_b   <= b;
        r_m   <= m;
        r_r   <= '0;
        r_cnt <= CW'(mul_latency(WIDTH) - 1);
        r_run <= 1'b1;
      end else if (r_run) begin
        r_a   <= r_a << 1;
        r_r   <= w_t2;
        r_cnt <= r_cnt - CW'(1);
        // Last bit: publish the product in the same edge as done.
        if (r_cnt == CW'(1)) begin
          r_run   <= 1'b0;
          product <= w_t2;
          done    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mod_exp.sv
// -----------------------------------------------------------------------------
// mod_exp
// Modular exponentiation, result = base^exp mod modulus, using right-to-left
// square-and-multiply. Every modular product goes through mod_mul_serial.
// Optional build macro: MOD_EXP_CONST_TIME_EN
//   defined   -> always walks all WIDTH exponent bits and always issues the
//                accumulator multiply (product discarded for 0 bits), giving
//                a fixed latency of 1 + (WIDTH+2)*(1+2*WIDTH) + 1 cycles.
//   undefined -> stops as soon as the shifted exponent is zero and skips the
//                multiply for 0 bits (data-dependent latency).
// Ports:
//   clk     : rising-edge clock
//   rst     : synchronous active-low reset
//   start   : request pulse, only sampled in IDLE
//   base    : message/ciphertext (may be >= modulus)
//   exp     : exponent
//   modulus : modulus n
//   result  : base^exp mod modulus, held until the next accepted start
//   valid   : one-cycle pulse when result is updated
//   busy    : high from the cycle after accept through the valid cycle
//   error   : set with valid when modulus == 0, cleared on next accept
// -----------------------------------------------------------------------------
module mod_exp
  import mod_exp_pkg::*;
#(
  parameter int WIDTH = MOD_EXP_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] exp,
  input  logic [WIDTH-1:0] modulus,
  output logic [WIDTH-1:0] result,
  output logic             valid,
  output logic             busy,
  output logic             error
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           r_state;
  logic [WIDTH-1:0] r_base;
  logic [WIDTH-1:0] r_esh;
  logic [WIDTH-1:0] r_mod;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_bred;
  logic             r_sq_wait;

`ifdef MOD_EXP_CONST_TIME_EN
  localparam int BW = $clog2(WIDTH + 1);
  logic [BW-1:0]    r_bits;
  logic [WIDTH-1:0] r_discard;
`endif

  logic             w_mod_ok;
  logic             w_step_done;
  logic             w_step_go;
  logic             w_mul_start;
  logic             w_mul_done;
  logic [WIDTH-1:0] w_mul_a;
  logic [WIDTH-1:0] w_mul_b;
  logic [WIDTH-1:0] w_mul_prod;

  assign w_mod_ok = |r_mod[WIDTH-1:1];

`ifdef MOD_EXP_CONST_TIME_EN
  assign w_step_done = (r_bits == '0);
  assign w_step_go   = 1'b1;
`else
  assign w_step_done = (r_esh == '0);
  assign w_step_go   = r_esh[0];
`endif

  // The multiplier is started in the first cycle of LOAD, STEP and SQR, so
  // each product costs that issue cycle plus the multiplier's own latency.
  always_comb begin
    w_mul_a     = '0;
    w_mul_b     = '0;
    w_mul_start = 1'b0;
    case (r_state)
      ST_LOAD: begin
        w_mul_a     = r_base;
        w_mul_b     = ONE;
        w_mul_start = w_mod_ok;
      end
      ST_STEP: begin
        w_mul_a     = r_acc;
        w_mul_b     = r_bred;
        w_mul_start = !w_step_done && w_step_go;
      end
      ST_SQR: begin
        w_mul_a     = r_bred;
        w_mul_b     = r_bred;
        w_mul_start = !r_sq_wait;
      end
      default: ;
    endcase
  end

  mod_mul_serial #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (w_mul_start),
    .a       (w_mul_a),
    .b       (w_mul_b),
    .m       (r_mod),
    .product (w_mul_prod),
    .done    (w_mul_done)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_base    <= '0;
      r_esh     <= '0;
      r_mod     <= '0;
      r_acc     <= '0;
      r_bred    <= '0;
      r_sq_wait <= 1'b0;
`ifdef MOD_EXP_CONST_TIME_EN
      r_bits    <= '0;
      r_discard <= '0;
`endif
      result    <= '0;
      valid     <= 1'b0;
      busy      <= 1'b0;
      error     <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_base  <= base;
            r_esh   <= exp;
            r_mod   <= modulus;
            busy    <= 1'b1;
            error   <= 1'b0;
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (!w_mod_ok) begin
            // modulus 0 is an error, modulus 1 is a legitimate zero result
            result  <= '0;
            error   <= (r_mod == '0);
            valid   <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_acc   <= ONE;
`ifdef MOD_EXP_CONST_TIME_EN
            r_bits  <= BW'(WIDTH);
`endif
            r_state <= ST_RED;
          end
        end
        ST_RED: begin
          if (w_mul_done) begin
            r_bred  <= w_mul_prod;
            r_state <= ST_STEP;
          end
        end
        ST_STEP: begin
          if (w_step_done) begin
            result  <= r_acc;
            valid   <= 1'b1;
            r_state <= ST_DONE;
          end else if (w_step_go) begin
            r_state <= ST_MUL;
          end else begin
            r_state <= ST_SQR;
          end
        end
        ST_MUL: begin
          if (w_mul_done) begin
`ifdef MOD_EXP_CONST_TIME_EN
            if (r_esh[0]) begin
              r_acc <= w_mul_prod;
            end else begin
              r_discard <= w_mul_prod;
            end
`else
            r_acc <= w_mul_prod;
`endif
            r_state <= ST_SQR;
          end
        end
        ST_SQR: begin
          if (!r_sq_wait) begin
            r_sq_wait <= 1'b1;
          end else if (w_mul_done) begin
            r_sq_wait <= 1'b0;
            r_bred    <= w_mul_prod;
            r_esh     <= r_esh >> 1;
`ifdef MOD_EXP_CONST_TIME_EN
            r_bits    <= r_bits - BW'(1);
`endif
            r_state   <= ST_STEP;
          end
        end
        ST_DONE: begin
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
